// File: rtl/dbg_uart_tx.sv
// dbg_uart_tx: serialises one captured 32-bit debug word as four back-to-back
// 8N1 UART frames, byte 0 first and each byte LSB first. Every bit is held for
// CLKS_PER_BIT clocks. An abort or a reset drops the word without a done pulse.
module dbg_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_abort,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] data_reg;

    logic [7:0]  cur_byte;
    logic        bit_end;

    // The byte currently on the line, and the last clock of the current bit.
    assign cur_byte = data_reg[{byte_idx, 3'b000} +: 8];
    assign bit_end  = (baud_cnt == BAUD_LAST);

    // Frame sequencer: registers the line, busy and done directly so every
    // output comes straight from a flop.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking ones would make order matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            data_reg <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_abort) begin
            // Abort wins over everything, including a simultaneous load.
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            data_reg <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_load) begin
                        data_reg <= i_data;
                        state    <= START;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        o_tx     <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            // Final stop bit done: release the line and flag
                            // completion; a new load is accepted this cycle.
                            state    <= IDLE;
                            byte_idx <= '0;
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                            o_tx     <= 1'b1;
                        end else begin
                            // Next frame starts immediately, no idle gap.
                            byte_idx <= byte_idx + 2'd1;
                            state    <= START;
                            o_tx     <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_uart_tx.sv
// tb_dbg_uart_tx: directed bench for dbg_uart_tx. Two instances are used, one
// at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1; sel chooses which one the
// stimulus drives and which one is observed.
module tb_dbg_uart_tx;

    typedef struct {
        string       name;
        logic        c1;
        logic [31:0] word;
        logic [31:0] expected;
        int          inject_at;
        logic [31:0] inject_word;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ld;
    logic        ab;
    logic [31:0] data;
    logic        sel;

    logic ld4, ab4, tx4, busy4, done4;
    logic ld1, ab1, tx1, busy1, done1;
    logic tx_s, busy_s, done_s;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[6];

    assign ld4 = ld & ~sel;
    assign ab4 = ab & ~sel;
    assign ld1 = ld & sel;
    assign ab1 = ab & sel;

    assign tx_s   = sel ? tx1   : tx4;
    assign busy_s = sel ? busy1 : busy4;
    assign done_s = sel ? done1 : done4;

    dbg_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .i_load (ld4),
        .i_data (data),
        .i_abort(ab4),
        .o_tx   (tx4),
        .o_busy (busy4),
        .o_done (done4)
    );

    dbg_uart_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .i_load (ld1),
        .i_data (data),
        .i_abort(ab1),
        .o_tx   (tx1),
        .o_busy (busy1),
        .o_done (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        ld   = 1'b1;
        data = w;
    endtask

    // Runs one word whose load is already presented: checks busy/done every
    // cycle, samples each bit mid-period, then checks framing, the decoded
    // word and the done pulse. Optionally injects a load while busy, or
    // chains a new load into the done cycle.
    task automatic body(input int c, input logic [31:0] exp, input int inject_at,
                        input logic [31:0] inject_word, input logic chain,
                        input logic [31:0] chain_word, input string name);
        logic [39:0] bits;
        logic [31:0] decoded;
        int total;
        total = 40 * c;
        bits  = '0;
        for (int n = 1; n <= total; n++) begin
            tick();
            if (n == inject_at) begin
                ld   = 1'b1;
                data = inject_word;
            end else begin
                ld = 1'b0;
            end
            check({name, " busy"}, {31'd0, busy_s}, 32'd1);
            check({name, " done_early"}, {31'd0, done_s}, 32'd0);
            if ((n - 1) % c == c / 2)
                bits[(n - 1) / c] = tx_s;
        end
        tick();
        ld = 1'b0;
        check({name, " end_busy"}, {31'd0, busy_s}, 32'd0);
        check({name, " end_done"}, {31'd0, done_s}, 32'd1);
        check({name, " end_tx"}, {31'd0, tx_s}, 32'd1);
        if (chain) begin
            ld   = 1'b1;
            data = chain_word;
        end
        decoded = '0;
        for (int k = 0; k < 4; k++) begin
            check({name, " start_bit"}, {31'd0, bits[10 * k]}, 32'd0);
            check({name, " stop_bit"}, {31'd0, bits[10 * k + 9]}, 32'd1);
            for (int i = 0; i < 8; i++)
                decoded[8 * k + i] = bits[10 * k + 1 + i];
        end
        check({name, " decoded"}, decoded, exp);
        if (!chain) begin
            tick();
            check({name, " done_pulse_1cyc"}, {31'd0, done_s}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{"w12345678",   1'b0, 32'h12345678, 32'h12345678, -1, 32'h0};
        vecs[1] = '{"ignore_load", 1'b0, 32'h12345678, 32'h12345678, 20, 32'hFFFFFFFF};
        vecs[2] = '{"c1_80000001", 1'b1, 32'h80000001, 32'h80000001, -1, 32'h0};
        vecs[3] = '{"all_zero",    1'b0, 32'h00000000, 32'h00000000, -1, 32'h0};
        vecs[4] = '{"all_one",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h0};
        vecs[5] = '{"c1_mixed",    1'b1, 32'hA5C33C5A, 32'hA5C33C5A, 3,  32'h0F0F0F0F};

        rst  = 1'b0;
        ld   = 1'b0;
        ab   = 1'b0;
        data = '0;
        sel  = 1'b0;

        // Reset state on both instances.
        #12;
        check("rst_tx4",   {31'd0, tx4},   32'd1);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_tx1",   {31'd0, tx1},   32'd1);
        check("rst_busy1", {31'd0, busy1}, 32'd0);

        // Release reset with a load already presented: first edge accepts it.
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].c1;
            issue(vecs[i].word);
            body(vecs[i].c1 ? 1 : 4, vecs[i].expected, vecs[i].inject_at,
                 vecs[i].inject_word, 1'b0, 32'h0, vecs[i].name);
            tick();
        end
        sel = 1'b0;

        // Abort beats a simultaneous load in IDLE.
        issue(32'h11223344);
        ab = 1'b1;
        tick();
        ld = 1'b0;
        ab = 1'b0;
        check("abort_prio_busy", {31'd0, busy4}, 32'd0);
        check("abort_prio_tx",   {31'd0, tx4},   32'd1);
        tick();

        // Back-to-back: second load in the done cycle starts next cycle.
        issue(32'hA5A5A5A5);
        body(4, 32'hA5A5A5A5, -1, 32'h0, 1'b1, 32'h0000003C, "b2b_first");
        body(4, 32'h0000003C, -1, 32'h0, 1'b0, 32'h0, "b2b_second");
        tick();

        // Abort at cycle 50 of a word, then a clean word.
        issue(32'h12345678);
        tick();
        ld = 1'b0;
        repeat (49) tick();
        ab = 1'b1;
        tick();
        ab = 1'b0;
        check("abort_tx",   {31'd0, tx4},   32'd1);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_done", {31'd0, done4}, 32'd0);
        for (int n = 0; n < 170; n++) begin
            tick();
            check("abort_no_done", {31'd0, done4}, 32'd0);
        end
        issue(32'h000000FF);
        body(4, 32'h000000FF, -1, 32'h0, 1'b0, 32'h0, "after_abort");
        tick();

        // Reset at cycle 30 of a word: asynchronous drop, no late done.
        issue(32'hA5A5A5A5);
        tick();
        ld = 1'b0;
        repeat (29) tick();
        rst = 1'b0;
        #2;
        check("async_rst_tx",   {31'd0, tx4},   32'd1);
        check("async_rst_busy", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick();
            check("rst_no_done", {31'd0, done4}, 32'd0);
            check("rst_idle_tx", {31'd0, tx4},   32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_uart_tx.md
DBG_UART_TX -- requirements
Module: dbg_uart_tx

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 87, clock cycles per serial bit, legal range 1..65535.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 i_load  input  1  one-cycle capture strobe from the debug fetch FSM (its enable output).
REQ-006 i_data  input  32  debug word, valid in the cycle i_load is high.
REQ-007 i_abort  input  1  synchronous abort, driven from CPU-reset-deasserted condition.
REQ-008 o_tx  output  1  UART serial line, idle high.
REQ-009 o_busy  output  1  high while a word is being transmitted.
REQ-010 o_done  output  1  one-cycle pulse when a word completes.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP.
- Counters: baud counter (CLKS_PER_BIT), bit index 0..7, byte index 0..3.
REQ-013 In IDLE with i_load=1 and i_abort=0, the block SHALL capture i_data, enter START, and drive o_tx=0, o_busy=1 from the next edge (1-cycle latency).
REQ-014 i_load SHALL be ignored whenever o_busy=1; the captured word SHALL NOT change mid-transmission.
REQ-015 The word SHALL be sent as 4 frames, byte 0 (i_data[7:0]) first, each frame = start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-016 Each bit SHALL be held on o_tx for exactly CLKS_PER_BIT cycles.
- START -> DATA after one bit time.
- DATA -> STOP after bit index 7 completes.
- STOP -> START (next byte) when byte index < 3.
- STOP -> IDLE after byte 3.
REQ-017 No idle gap SHALL exist between frames; total word time from o_tx falling to o_done SHALL be 40*CLKS_PER_BIT cycles.
REQ-018 At the edge ending the final stop bit, the block SHALL return to IDLE, drive o_busy=0 and o_done=1 for exactly one cycle, with o_tx=1.
REQ-019 i_load asserted in the cycle o_busy is 0 (including the o_done cycle) SHALL be accepted; back-to-back words SHALL have no gap beyond that one cycle.
REQ-020 i_abort=1 in any state SHALL force IDLE on the next edge with o_tx=1, o_busy=0, o_done=0, counters cleared; abort SHALL take priority over simultaneous i_load.
REQ-021 With CLKS_PER_BIT=1, the block SHALL change bit every cycle with no dropped or repeated bits.

Reset
REQ-022 While rst=0, the block SHALL be in IDLE with o_tx=1, o_busy=0, o_done=0, all counters and the data register cleared.
REQ-023 Reset asserted mid-transmission SHALL immediately abandon the word; no o_done SHALL follow the release of reset.
REQ-024 The first i_load SHALL be accepted on the first edge after rst is deasserted.

Verification
REQ-025 CLKS_PER_BIT=4, i_load with 0x12345678 -> o_tx serializes bytes 0x78,0x56,0x34,0x12 as LSB-first frames, o_busy high 160 cycles, o_done pulses once at cycle 160.
REQ-026 During the 0x12345678 transfer, i_load with 0xFFFFFFFF at cycle 20 -> ignored; the decoded output stays 0x78,0x56,0x34,0x12.
REQ-027 i_load 0xA5A5A5A5 then i_load 0x0000003C in the o_done cycle -> second word starts next cycle, decoded 0xA5,0xA5,0xA5,0xA5,0x3C,0x00,0x00,0x00.
REQ-028 i_abort at cycle 50 of a word -> next cycle o_tx=1, o_busy=0; no o_done; a following i_load 0x000000FF transmits cleanly.
REQ-029 rst pulled low at cycle 30 of a word -> o_tx=1, o_busy=0 asynchronously; after release o_done stays 0 for 200 cycles.
REQ-030 CLKS_PER_BIT=1, i_load 0x80000001 -> 40-cycle word, decoded bytes 0x01,0x00,0x00,0x80.
